// File: rtl/pwm_pkg.sv
// ============================================================================
//  Module   : pwm_pkg
//  Purpose  : Shared types and defaults for the PWM generator / dead-time path
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

  // Bridge-leg states: both off, dead interval, high side on, low side on
  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_DEAD = 2'd1,
    ST_HI   = 2'd2,
    ST_LO   = 2'd3
  } state_t;

  // Shortest dead interval ever allowed; must be at least 1 so that a
  // dead interval always expires
  localparam int DT_MIN_DEFAULT = 1;

  // Duty width shared with triangular_pwm
  localparam int DUTY_WIDTH = 8;

endpackage

`default_nettype wire

// File: rtl/pwm_deadtime_if.sv
// ============================================================================
//  Module   : pwm_deadtime_if
//  Purpose  : Command/gate bundle between a PWM controller and one bridge leg
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface pwm_deadtime_if #(
  parameter int DT_WIDTH = 8
);
  logic                pwm_in;
  logic                enable;
  logic [DT_WIDTH-1:0] dead_time;
  logic                fault;
  logic                clear_fault;
  logic                gate_hi;
  logic                gate_lo;
  logic                dt_active;
  logic                fault_latched;

  // Controller side: issues commands, observes gate state
  modport master (
    output pwm_in, enable, dead_time, fault, clear_fault,
    input  gate_hi, gate_lo, dt_active, fault_latched
  );

  // Dead-time block side
  modport slave (
    input  pwm_in, enable, dead_time, fault, clear_fault,
    output gate_hi, gate_lo, dt_active, fault_latched
  );
endinterface

`default_nettype wire

// File: rtl/dt_counter.sv
// ============================================================================
//  Module   : dt_counter
//  Purpose  : Loadable down-counter timing one dead interval; expired is high
//             while the final cycle of the interval is being counted
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dt_counter #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load,
  input  wire logic [WIDTH-1:0] load_value,
  input  wire logic             dec,
  output logic      [WIDTH-1:0] value,
  output logic                  expired
);

  // Load takes priority; decrement saturates at zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (dec && (value != '0)) begin
      value <= value - WIDTH'(1);
    end
  end

  assign expired = (value == WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/pwm_deadtime.sv
// ============================================================================
//  Module   : pwm_deadtime
//  Purpose  : Complementary half-bridge gate drive with programmable dead
//             time, enable and latched fault shutdown
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DT_WIDTH = 8,
  parameter int DT_MIN   = DT_MIN_DEFAULT
) (
  input  wire logic     clk,
  input  wire logic     rst,
  pwm_deadtime_if.slave bus
);

  localparam logic [DT_WIDTH-1:0] DT_MIN_V = DT_WIDTH'(DT_MIN);

  state_t              state;
  logic                pwm_q;
  logic                fault_latched;
  logic                gate_hi;
  logic                gate_lo;
  logic                dt_active;
  logic [DT_WIDTH-1:0] dt_eff;
  logic [DT_WIDTH-1:0] cnt_value;
  logic                cnt_expired;
  logic                go_dead;
  logic                run_ok;

  // Short dead_time requests are raised to the minimum interval
  assign dt_eff  = (bus.dead_time < DT_MIN_V) ? DT_MIN_V : bus.dead_time;

  // Normal switching only when no fault input and the bridge is enabled
  assign run_ok  = !bus.fault && bus.enable;

  // Conditions that open a dead interval (start-up or commanded level change)
  assign go_dead = run_ok &&
                   (((state == ST_OFF) && !fault_latched) ||
                    ((state == ST_HI)  && !pwm_q) ||
                    ((state == ST_LO)  &&  pwm_q));

  dt_counter #(
    .WIDTH (DT_WIDTH)
  ) u_dt_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (go_dead),
    .load_value (dt_eff),
    .dec        (state == ST_DEAD),
    .value      (cnt_value),
    .expired    (cnt_expired)
  );

  // Synchronise the PWM command; the FSM only ever looks at pwm_q
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pwm_q <= 1'b0;
    else      pwm_q <= bus.pwm_in;
  end

  // Sticky fault flag; a fault asserted together with clear wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 fault_latched <= 1'b0;
    else if (bus.fault)       fault_latched <= 1'b1;
    else if (bus.clear_fault) fault_latched <= 1'b0;
  end

  // Leg FSM with registered gate outputs; at most one gate set per branch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_OFF;
      gate_hi   <= 1'b0;
      gate_lo   <= 1'b0;
      dt_active <= 1'b0;
    end else if (!run_ok) begin
      state     <= ST_OFF;
      gate_hi   <= 1'b0;
      gate_lo   <= 1'b0;
      dt_active <= 1'b0;
    end else begin
      case (state)
        ST_OFF, ST_HI, ST_LO: begin
          if (go_dead) begin
            state     <= ST_DEAD;
            gate_hi   <= 1'b0;
            gate_lo   <= 1'b0;
            dt_active <= 1'b1;
          end
        end
        ST_DEAD: begin
          // Level resolved at expiry, so pulses shorter than D vanish
          if (cnt_expired) begin
            state     <= pwm_q ? ST_HI : ST_LO;
            gate_hi   <= pwm_q;
            gate_lo   <= !pwm_q;
            dt_active <= 1'b0;
          end
        end
        default: begin
          state     <= ST_OFF;
          gate_hi   <= 1'b0;
          gate_lo   <= 1'b0;
          dt_active <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gate_hi       = gate_hi;
  assign bus.gate_lo       = gate_lo;
  assign bus.dt_active     = dt_active;
  assign bus.fault_latched = fault_latched;

endmodule

`default_nettype wire
